seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 18 +
 rtl/seg_scan_ctrl_hex7_dec.sv | 11 +
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display constants: field widths, blank pattern and the hex-to-segment table.
package seg_scan_ctrl_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned ADDR_W = 3;

    // Active-low segments, bit6=a ... bit0=g; all ones turns every segment off.
    localparam logic [SEG_W-1:0] BLANK_PAT = 7'b1111111;

    localparam logic [SEG_W-1:0] HEX7_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg_scan_ctrl_hex7_dec.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7_dec
    import seg_scan_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = HEX7_LUT[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a host shadow bank that is
// transferred to the scanned display bank only on frame boundaries.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NDIG  = 8,
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NIB_W-1:0]  wr_data,
    input  logic              commit,
    input  logic [NDIG-1:0]   digit_en,
    output logic [NDIG-1:0]   an,
    output logic [SEG_W-1:0]  seg,
    output logic              busy,
    output logic              frame_start
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(NDIG);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic [NDIG-1:0]  an_q, an_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             frame_start_q, frame_start_d;
    logic [NIB_W-1:0] shadow_q [NDIG];
    logic [NIB_W-1:0] disp_q   [NDIG];

    logic             slot_end_c;
    logic             frame_end_c;
    logic             wr_fire_c;
    logic             commit_fire_c;
    logic             blank_c;
    logic [NIB_W-1:0] cur_nib_c;
    logic [SEG_W-1:0] dec_seg_c;

    hex7_dec u_dec (
        .nib_i (cur_nib_c),
        .seg_o (dec_seg_c)
    );

    // Prescaler, digit index, commit handshake and next output values.
    always_comb begin
        slot_end_c    = (cnt_q == CNT_W'(DIV - 1));
        frame_end_c   = slot_end_c && (idx_q == IDX_W'(NDIG - 1));
        wr_fire_c     = wr_valid && !busy_q;
        commit_fire_c = commit && !busy_q;
        blank_c       = (cnt_q < CNT_W'(BLANK));
        cur_nib_c     = disp_q[idx_q];

        cnt_d = slot_end_c ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end_c) begin
            idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        // A commit landing on the boundary cycle sees busy_q=0, so it waits a full frame.
        busy_d = busy_q;
        if (frame_end_c && busy_q) begin
            busy_d = 1'b0;
        end else if (commit_fire_c) begin
            busy_d = 1'b1;
        end

        an_d  = '1;
        seg_d = BLANK_PAT;
        if (!blank_c) begin
            seg_d = dec_seg_c;
            if (digit_en[idx_q]) begin
                an_d = ~(NDIG'(1) << idx_q);
            end
        end
        frame_start_d = frame_end_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            an_q          <= '1;
            seg_q         <= BLANK_PAT;
            frame_start_q <= 1'b0;
            for (int unsigned i = 0; i < NDIG; i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
            // Full-width address compare drops writes to digits that do not exist.
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (wr_fire_c && (wr_addr == ADDR_W'(i))) begin
                    shadow_q[i] <= wr_data;
                end
                if (frame_end_c && busy_q) begin
                    disp_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign wr_ready    = ~busy_q;
    assign busy        = busy_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at NDIG=4, DIV=8, BLANK=2.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       commit = 1'b0;
    logic [3:0] digit_en = 4'hF;
    logic       wr_ready;
    logic [3:0] an;
    logic [6:0] seg;
    logic       busy;
    logic       frame_start;

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .digit_en    (digit_en),
        .an          (an),
        .seg         (seg),
        .busy        (busy),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        int         adv;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } vec_t;

    vec_t       tbl [19];
    logic [6:0] dec_tbl [16];
    logic [3:0] cur_disp [4];
    logic [3:0] pend_disp [4];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    logic       exp_busy = 1'b0;
    logic       ev_on = 1'b0;
    int         ev_cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // One clock; checks every output against the scan timing and the expected display bank.
    task automatic tick();
        int s, c, d;
        logic [3:0] ean;
        logic [6:0] eseg;
        @(posedge clk);
        #1;
        cyc++;
        if (ev_on && cyc == ev_cyc) exp_busy = 1'b0;
        s = cyc - 1;
        c = s % DIV;
        d = (s / DIV) % NDIG;
        ean = 4'hF;
        if (c >= BLANK && digit_en[d]) ean = ~(4'(1) << d);
        eseg = (c < BLANK) ? 7'h7F : dec_tbl[cur_disp[d]];
        chk("an", 32'(an), 32'(ean));
        chk("seg", 32'(seg), 32'(eseg));
        chk("frame_start", 32'(frame_start), 32'((s % FRAME) == FRAME - 1));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("wr_ready", 32'(wr_ready), 32'(!exp_busy));
        if (ev_on && cyc == ev_cyc) begin
            cur_disp = pend_disp;
            ev_on = 1'b0;
        end
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] dd, input logic c);
        chk("wr_ready_pre", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = dd;
        commit   = c;
        tick();
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    // Asserts rst between clock edges, checks the asynchronous effect, then releases.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        exp_busy = 1'b0;
        ev_on = 1'b0;
        for (int i = 0; i < 4; i++) cur_disp[i] = 4'h0;
    endtask

    initial begin
        dec_tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                    7'h00, 7'h04, 7'h08, 7'h60, 7'h72, 7'h42, 7'h30, 7'h38};
        // Cumulative cycles: 1,2,3,8,9,11,19,27,32,33,64,67,75,83,91,96,99,100,101
        tbl[0]  = '{4'hF, 1,  4'hF, 7'h7F, 1'b0};
        tbl[1]  = '{4'hF, 1,  4'hF, 7'h7F, 1'b0};
        tbl[2]  = '{4'hF, 1,  4'hE, 7'h01, 1'b0};
        tbl[3]  = '{4'hF, 5,  4'hE, 7'h01, 1'b0};
        tbl[4]  = '{4'hF, 1,  4'hF, 7'h7F, 1'b0};
        tbl[5]  = '{4'hF, 2,  4'hD, 7'h01, 1'b0};
        tbl[6]  = '{4'hF, 8,  4'hB, 7'h01, 1'b0};
        tbl[7]  = '{4'hF, 8,  4'h7, 7'h01, 1'b0};
        tbl[8]  = '{4'hF, 5,  4'h7, 7'h01, 1'b1};
        tbl[9]  = '{4'hF, 1,  4'hF, 7'h7F, 1'b0};
        tbl[10] = '{4'hF, 31, 4'h7, 7'h01, 1'b1};
        tbl[11] = '{4'hA, 3,  4'hF, 7'h01, 1'b0};
        tbl[12] = '{4'hA, 8,  4'hD, 7'h01, 1'b0};
        tbl[13] = '{4'hA, 8,  4'hF, 7'h01, 1'b0};
        tbl[14] = '{4'hA, 8,  4'h7, 7'h01, 1'b0};
        tbl[15] = '{4'hA, 5,  4'h7, 7'h01, 1'b1};
        tbl[16] = '{4'hF, 3,  4'hE, 7'h01, 1'b0};
        tbl[17] = '{4'hE, 1,  4'hF, 7'h01, 1'b0};
        tbl[18] = '{4'hF, 1,  4'hE, 7'h01, 1'b0};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            digit_en = tbl[i].en;
            repeat (tbl[i].adv) tick();
            chk("tbl_an", 32'(an), 32'(tbl[i].an));
            chk("tbl_seg", 32'(seg), 32'(tbl[i].seg));
            chk("tbl_frame_start", 32'(frame_start), 32'(tbl[i].fs));
        end
        digit_en = 4'hF;

        // Shadow writes, out-of-range addresses, write+commit in one cycle, mid-frame commit.
        do_reset();
        run_to(4);
        wr(3'd0, 4'hA, 1'b0);
        wr(3'd1, 4'hB, 1'b0);
        wr(3'd2, 4'hC, 1'b0);
        wr(3'd5, 4'h9, 1'b0);
        wr(3'd7, 4'hE, 1'b0);
        exp_busy = 1'b1;
        ev_on = 1'b1;
        ev_cyc = 32;
        pend_disp = '{4'hA, 4'hB, 4'hC, 4'hD};
        wr(3'd3, 4'hD, 1'b1);
        chk("busy_after_commit", 32'(busy), 32'd1);

        // Write held while busy must wait until busy drops.
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 4'h5;
        run_to(32);
        run_to(33);
        wr_valid = 1'b0;
        run_to(35);
        chk("dig0_A", 32'(seg), 32'h08);
        run_to(39);
        exp_busy = 1'b1;
        ev_on = 1'b1;
        ev_cyc = 64;
        pend_disp = '{4'hA, 4'hB, 4'h5, 4'hD};
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run_to(43);
        chk("dig1_B", 32'(seg), 32'h60);
        run_to(51);
        chk("dig2_C", 32'(seg), 32'h72);
        run_to(59);
        chk("dig3_D", 32'(seg), 32'h42);
        run_to(83);
        chk("dig2_5", 32'(seg), 32'h24);

        // Commit exactly on the boundary cycle applies one frame later; commit while busy ignored.
        run_to(96);
        wr(3'd0, 4'hF, 1'b0);
        run_to(127);
        exp_busy = 1'b1;
        ev_on = 1'b1;
        ev_cyc = 160;
        pend_disp = '{4'hF, 4'hB, 4'h5, 4'hD};
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run_to(131);
        chk("dig0_still_A", 32'(seg), 32'h08);
        run_to(140);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run_to(163);
        chk("dig0_F", 32'(seg), 32'h38);
        chk("busy_clear", 32'(busy), 32'd0);
        run_to(170);

        // Asynchronous reset mid-slot with a pending commit.
        exp_busy = 1'b1;
        ev_on = 1'b1;
        ev_cyc = 192;
        pend_disp = cur_disp;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run_to(180);
        do_reset();
        run_to(3);
        chk("post_rst_an", 32'(an), 32'hE);
        chk("post_rst_seg", 32'(seg), 32'h01);
        run_to(40);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
